// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: moves the operand by at most STEP positions per clock
// in one of four modes, with a Start/Busy/Done handshake.
module iterative_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Number,
  input  logic [AMT_W-1:0] Range,
  input  logic [1:0]       Mode,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Shifted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] ZERO_A = {AMT_W{1'b0}};

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [AMT_W-1:0]   rem_q;
  logic [1:0]         mode_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   shifted_q;

  logic [AMT_W-1:0]   k_s;
  logic [AMT_W-1:0]   rem_d;
  logic [WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0] rot_s;

  // One iteration of the datapath: shift the accumulator by min(STEP, rem).
  // The arithmetic fill comes from acc MSB, which never changes while shifting right arithmetically.
  always_comb begin
    rot_s = {acc_q, acc_q};
    if (rem_q > STEP_A) begin
      k_s = STEP_A;
    end else begin
      k_s = rem_q;
    end
    rem_d = rem_q - k_s;
    case (mode_q)
      2'b00:   acc_d = acc_q >> k_s;
      2'b01:   acc_d = $signed(acc_q) >>> k_s;
      2'b10:   acc_d = acc_q << k_s;
      2'b11: begin
        rot_s = {acc_q, acc_q} >> k_s;
        acc_d = rot_s[WIDTH-1:0];
      end
      default: acc_d = acc_q;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= {WIDTH{1'b0}};
      rem_q     <= ZERO_A;
      mode_q    <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shifted_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        S_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == ZERO_A) begin
            state_q   <= S_FINISH;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            shifted_q <= acc_d;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_IDLE, S_FINISH: begin
          done_q <= 1'b0;
          if (Start) begin
            acc_q  <= Number;
            rem_q  <= Range;
            mode_q <= Mode;
            if (Range != ZERO_A) begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
            end else begin
              // A zero-length shift completes straight away with the operand unchanged.
              state_q   <= S_FINISH;
              done_q    <= 1'b1;
              shifted_q <= Number;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Shifted = shifted_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed self-checking bench: a STEP=1 and a STEP=4 instance, both 16 bits wide.
module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start4;
  logic [15:0] number;
  logic [3:0]  range;
  logic [1:0]  mode;
  logic        busy1, done1, busy4, done4;
  logic [15:0] sh1, sh4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(16), .STEP(1)) u_step1 (
    .Clock(clk), .Reset_n(rst_n), .Start(start1), .Number(number),
    .Range(range), .Mode(mode), .Busy(busy1), .Done(done1), .Shifted(sh1)
  );

  iterative_shifter #(.WIDTH(16), .STEP(4)) u_step4 (
    .Clock(clk), .Reset_n(rst_n), .Start(start4), .Number(number),
    .Range(range), .Mode(mode), .Busy(busy4), .Done(done4), .Shifted(sh4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the first cycle after the accepting edge; returns
  // the 1-based cycle index of Done (0 on timeout) and the number of Busy cycles.
  task automatic wait_done(input bit sel, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      if (sel ? busy4 : busy1) nbusy++;
      if (sel ? done4 : done1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input bit sel, input logic [15:0] n,
                        input logic [3:0] r, input logic [1:0] m,
                        input logic [15:0] exp, input int exp_lat);
    int lat, nbusy;
    @(negedge clk);
    number = n; range = r; mode = m;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    wait_done(sel, lat, nbusy);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, 32'(nbusy), 32'(exp_lat - 1));
    check({tag, " result"}, {16'h0000, sel ? sh4 : sh1}, {16'h0000, exp});
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, sel ? done4 : done1}, 32'd0);
  endtask

  initial begin
    int lat, nbusy, ndone;
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    number = 16'h0000; range = 4'd0; mode = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset busy1", {31'd0, busy1}, 32'd0);
    check("reset done1", {31'd0, done1}, 32'd0);
    check("reset sh1", {16'h0000, sh1}, 32'h0000);
    check("reset busy4", {31'd0, busy4}, 32'd0);
    check("reset sh4", {16'h0000, sh4}, 32'h0000);

    run_op("s1 asr", 1'b0, 16'h8004, 4'd3, 2'b01, 16'hF000, 4);
    run_op("s1 lsr", 1'b0, 16'h8004, 4'd3, 2'b00, 16'h1000, 4);
    run_op("s1 lsl", 1'b0, 16'h8004, 4'd3, 2'b10, 16'h0020, 4);
    run_op("s1 ror", 1'b0, 16'h8004, 4'd3, 2'b11, 16'h9000, 4);
    run_op("s1 zero", 1'b0, 16'h1234, 4'd0, 2'b10, 16'h1234, 1);
    run_op("s4 lsr15", 1'b1, 16'hFFFF, 4'd15, 2'b00, 16'h0001, 5);
    run_op("s4 asr5", 1'b1, 16'h8000, 4'd5, 2'b01, 16'hFC00, 3);
    run_op("s4 ror7", 1'b1, 16'h1234, 4'd7, 2'b11, 16'h6824, 3);
    run_op("s4 zero", 1'b1, 16'hBEEF, 4'd0, 2'b01, 16'hBEEF, 1);

    // Start during SHIFT is ignored; Start in the FINISH cycle is accepted back-to-back.
    @(negedge clk);
    number = 16'h8004; range = 4'd3; mode = 2'b01; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("ign busy", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    number = 16'h00FF; range = 4'd1; mode = 2'b10; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("ign done", {31'd0, done1}, 32'd1);
    check("ign result", {16'h0000, sh1}, 32'h0000F000);
    number = 16'h0F0F; range = 4'd4; mode = 2'b11; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, lat, nbusy);
    check("b2b latency", 32'(lat), 32'd5);
    check("b2b busy", 32'(nbusy), 32'd4);
    check("b2b result", {16'h0000, sh1}, 32'h0000F0F0);

    // Reset mid-SHIFT aborts the operation without a Done.
    @(negedge clk);
    number = 16'hFFFF; range = 4'd8; mode = 2'b00; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst busy", {31'd0, busy1}, 32'd0);
    check("rst done", {31'd0, done1}, 32'd0);
    check("rst result", {16'h0000, sh1}, 32'h0000);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("rst no done", 32'(ndone), 32'd0);
    run_op("post rst", 1'b0, 16'h00F0, 4'd2, 2'b10, 16'h03C0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Parametrised, multi-cycle shifter and successor to the team's 16-bit combinational right shifter.
- Adds a selectable shift mode: logical right, arithmetic right, logical left, rotate right.
- Shifts by up to STEP bit positions per clock, with a Start/Busy/Done handshake.
- Sits in the ALU datapath wherever a shift can take several cycles in exchange for a smaller area than a full barrel shifter.

Parameters:
- WIDTH, 16, operand width in bits; must be a power of two, 4 or more.
- STEP, 1, maximum bit positions shifted per cycle; must satisfy 1 <= STEP <= WIDTH-1.
- AMT_W (localparam), $clog2(WIDTH), width of the shift amount.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset.
- Start  input  1  request pulse; sampled every cycle.
- Number  input  WIDTH  operand; captured when a request is accepted.
- Range  input  AMT_W  shift amount, 0..WIDTH-1; captured when a request is accepted.
- Mode  input  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right; captured when a request is accepted.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse marking that a result is ready.
- Shifted  output  WIDTH  last completed result; held until the next completion.

Behaviour:
- One clock (Clock). Reset is synchronous and active-low (Reset_n). Both are fixed.
- Reset (Reset_n=0 at a rising edge):
  - State goes to IDLE.
  - Busy=0, Done=0, Shifted=0.
  - Internal accumulator and remaining count are cleared.
  - Any operation in progress is aborted with no Done.
- States: IDLE, SHIFT, FINISH.
- Accept: Start=1 at a rising edge while in IDLE or FINISH.
  - Number, Range and Mode are latched. Acc=Number, Rem=Range.
  - If Range!=0, next state is SHIFT. If Range==0, next state is FINISH.
- SHIFT, each cycle:
  - k = min(STEP, Rem). Acc is shifted by k positions according to the latched Mode. Rem = Rem-k.
  - When Rem becomes 0, next state is FINISH.
  - Busy=1 throughout SHIFT.
- FINISH (exactly one cycle):
  - Done=1, Busy=0, and Shifted is loaded with Acc. Shifted is registered, so it is valid in the same cycle Done is high.
  - Next state is IDLE, or SHIFT/FINISH if Start=1 (back-to-back accept).
- Latency: Done is high in cycle A+ceil(Range/STEP)+1, where A is the cycle of the accepting edge.
- Start while in SHIFT is ignored: not queued, no error.
- Changes on Number/Range/Mode after acceptance have no effect on the operation in progress.
- Mode rules:
  - Logical right: zero fill at the MSB end.
  - Arithmetic right: fill with the latched Number[WIDTH-1].
  - Logical left: zero fill at the LSB end. Bits shifted out are lost.
  - Rotate right: bits leaving bit 0 re-enter at bit WIDTH-1.
- A full shift by Range is exact; the result equals a single shift of Number by Range. Range is never wider than AMT_W, so there is no out-of-range case.
- Shifted changes only in FINISH or on reset. Done never asserts twice for one accept.

Test Plan:
- WIDTH=16, STEP=1: Number=0x8004, Range=3, Mode=01, Start pulse -> Busy high 3 cycles, Done at A+4, Shifted=0xF000.
- Same operand, Modes 00, 10 and 11 in turn -> Shifted=0x1000, 0x0020 and 0x9000 respectively, each with Done at A+4.
- Range=0, Number=0x1234, any Mode -> Busy never high, Done at A+1, Shifted=0x1234.
- WIDTH=16, STEP=4: Number=0xFFFF, Range=15, Mode=00 -> 4 SHIFT cycles, Done at A+5, Shifted=0x0001.
- During SHIFT: pulse Start with new operands -> ignored; result matches the first request. Then Start held high in the FINISH cycle -> second op accepted back-to-back, and its Done follows the latency formula.
- Reset_n=0 for one cycle mid-SHIFT -> next cycle Busy=0, Done=0, Shifted=0; no Done follows. A new Start afterwards completes normally.
